matrix_stream_feeder: RTL and testbench
=======================================

Name: matrix_stream_feeder

Overview:
- Upstream source for the systolic matrix multiplier.
- Buffers two n×n operand matrices (A, B), written over a simple write port, then streams n² operand pairs on a strobe/acknowledge handshake in the order the PE chain consumes them.
- A is streamed row-major; B is streamed column-major (transposed).
- One block instance drives one multiplier's a/b/in_stb inputs and observes its in_ack.

Parameters:
- LOG_SIZE, 2, log2 of matrix dimension; n = 2**LOG_SIZE.
- DATA_W, 32, operand width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  target buffer: 0 = A, 1 = B.
- wr_addr  in  2*LOG_SIZE  element index, row-major: {row, col}.
- wr_data  in  DATA_W  element value.
- start  in  1  single-cycle pulse; begins a stream pass.
- out_a  out  DATA_W  A operand to the multiplier.
- out_b  out  DATA_W  B operand to the multiplier.
- out_stb  out  1  out_a/out_b valid.
- out_ack  in  1  multiplier accepts the current pair.
- busy  out  1  high from the cycle after an accepted start until the last transfer.
- done  out  1  one-cycle pulse after the last transfer.
- wr_err  out  1  one-cycle pulse when a write is dropped because busy = 1.

Behaviour:
- Storage: two register arrays of n² × DATA_W each. They are not cleared by rst; contents persist across passes and resets.
- Reset: out_stb = 0, busy = 0, done = 0, wr_err = 0, out_a = 0, out_b = 0, index k = 0, FSM = IDLE.
- FSM states:
  - IDLE: writes accepted; out_stb = 0.
  - STREAM: pairs presented.
  - Transitions: IDLE -> STREAM on start. STREAM -> IDLE on transfer of k = n²-1.
- Writes: in IDLE, wr_en stores wr_data at wr_addr of the selected buffer on the clock edge. In STREAM, writes are dropped and wr_err pulses the next cycle.
- start in IDLE: on the next edge busy = 1, out_stb = 1, and out_a/out_b hold the pair for k = 0 (latency 1 cycle). start in STREAM is ignored.
- Pair for index k: r = k >> LOG_SIZE, c = k & (n-1).
  - out_a = A[r][c].
  - out_b = B[c][r].
- Transfer occurs when out_stb && out_ack at a rising edge.
- Holding rule: while out_stb = 1 and out_ack = 0, out_a, out_b and out_stb hold stable.
- On a transfer with k < n²-1: k increments, and the registered outputs load pair k+1 at the same edge. out_stb stays 1, so there are no bubbles; continuous ack gives one pair per cycle.
- On the transfer of k = n²-1: next edge out_stb = 0, busy = 0, done = 1 for one cycle, k = 0, FSM = IDLE. out_a/out_b keep their last values.
- Simultaneous events:
  - start and wr_en in the same IDLE cycle: the write commits, and pair 0 is read after the write, so it reflects the new data when addressed (write-first).
  - done cycle with start asserted: the block is in IDLE, so the new pass begins.
- out_ack while out_stb = 0: ignored.
- rst mid-stream: next edge out_stb = 0, busy = 0, k = 0, no done pulse. Buffers are retained.
- Index width: k has 2*LOG_SIZE bits; the last-element compare uses all-ones, with no wrap-around beyond it.

Decomposition:
- Shared package: DATA_W default, FSM state encoding (IDLE, STREAM), and a helper for n = 2**LOG_SIZE.
- One natural sub-module: matrix_operand_buffer, an n² × DATA_W register file with one sync write port and one combinational read port. It is instantiated twice, for A and B.
- FSM, index counter and output registers stay in the top level.

Test Plan:
- Load A[i] = i and B[i] = 16+i (i = 0..15), start, hold out_ack = 1 → 16 consecutive transfers with no bubble.
  - Transfer 0: (0, 16). Transfer 1: (1, 20). Transfer 4: (4, 17). Transfer 15: (15, 31).
  - done pulses the cycle after transfer 15, and busy falls in that same cycle.
- Same data, out_ack toggles 1/0 each cycle → pairs held stable during ack-low cycles, the sequence is unchanged, and 16 transfers complete in 31 cycles.
- During STREAM, write A[0] = 0xDEAD → wr_err pulses once, and the next pass still yields out_a = 0 at k = 0.
- Assert rst after transfer 5, then start → out_stb drops the cycle after rst with no done pulse. The new pass restarts at (0, 16) with the buffers intact.
- Assert start while busy at k = 7 → ignored; the pass ends normally after transfer 15 with exactly one done pulse.
- Write B[0] = 0x55 and start in the same cycle → the first pair is (0, 0x55).

Source files
------------

// File: rtl/matrix_stream_feeder_pkg.sv
// Shared types and constants for the matrix stream feeder: default operand
// width, FSM state encoding and the matrix dimension helper.
package matrix_stream_feeder_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } feeder_state_t;

  function automatic int mat_dim(input int log_size);
    return 32'sd1 <<< log_size;
  endfunction

endpackage

// File: rtl/matrix_stream_feeder_buffer.sv
// n*n operand register file: one synchronous write port and one combinational
// write-first read port (a same-cycle write to the read address is forwarded).
module matrix_operand_buffer
  import matrix_stream_feeder_pkg::*;
#(
  parameter int LOG_SIZE = 2,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [2*LOG_SIZE-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2*LOG_SIZE-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = mat_dim(LOG_SIZE) * mat_dim(LOG_SIZE);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read with forwarding so a pass started alongside a write sees the new value.
  always_comb begin
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/matrix_stream_feeder.sv
// Buffers operand matrices A and B and streams n*n pairs (A row-major,
// B column-major) to a systolic multiplier over a stb/ack handshake.
module matrix_stream_feeder
  import matrix_stream_feeder_pkg::*;
#(
  parameter int LOG_SIZE = 2,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [2*LOG_SIZE-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);

  localparam int AW = 2 * LOG_SIZE;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  feeder_state_t     state_r, state_s;
  logic [AW-1:0]     k_r, k_s;
  logic [AW-1:0]     rd_idx_s, rd_addr_b_s;
  logic [DATA_W-1:0] rd_a_s, rd_b_s;
  logic [DATA_W-1:0] out_a_s, out_b_s;
  logic              out_stb_s, busy_s, done_s, wr_err_s;
  logic              wr_a_s, wr_b_s;

  assign wr_a_s = wr_en & ~wr_sel & (state_r == ST_IDLE);
  assign wr_b_s = wr_en &  wr_sel & (state_r == ST_IDLE);

  // Index of the pair to load next: 0 when launching, k+1 while streaming.
  always_comb begin
    if (state_r == ST_STREAM) begin
      rd_idx_s = k_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_idx_s = {AW{1'b0}};
    end
  end

  // B is read transposed: element B[c][r] lives at {c, r}.
  assign rd_addr_b_s = {rd_idx_s[LOG_SIZE-1:0], rd_idx_s[AW-1:LOG_SIZE]};

  matrix_operand_buffer #(.LOG_SIZE(LOG_SIZE), .DATA_W(DATA_W)) u_buf_a (
    .clk     (clk),
    .wr_en   (wr_a_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_idx_s),
    .rd_data (rd_a_s)
  );

  matrix_operand_buffer #(.LOG_SIZE(LOG_SIZE), .DATA_W(DATA_W)) u_buf_b (
    .clk     (clk),
    .wr_en   (wr_b_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_b_s),
    .rd_data (rd_b_s)
  );

  // Next-state, index and output-register logic.
  always_comb begin
    state_s   = state_r;
    k_s       = k_r;
    out_a_s   = out_a;
    out_b_s   = out_b;
    out_stb_s = out_stb;
    busy_s    = busy;
    done_s    = 1'b0;
    wr_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_STREAM;
          k_s       = {AW{1'b0}};
          out_a_s   = rd_a_s;
          out_b_s   = rd_b_s;
          out_stb_s = 1'b1;
          busy_s    = 1'b1;
        end else begin
          out_stb_s = 1'b0;
        end
      end
      ST_STREAM: begin
        wr_err_s = wr_en;
        if (out_ack && (k_r == LAST_IDX)) begin
          state_s   = ST_IDLE;
          k_s       = {AW{1'b0}};
          out_stb_s = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
        end else if (out_ack) begin
          k_s     = rd_idx_s;
          out_a_s = rd_a_s;
          out_b_s = rd_b_s;
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        k_s       = {AW{1'b0}};
        out_stb_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_r     <= {AW{1'b0}};
      out_a   <= {DATA_W{1'b0}};
      out_b   <= {DATA_W{1'b0}};
      out_stb <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      out_a   <= out_a_s;
      out_b   <= out_b_s;
      out_stb <= out_stb_s;
      busy    <= busy_s;
      done    <= done_s;
      wr_err  <= wr_err_s;
    end
  end

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Randomized scoreboard bench for matrix_stream_feeder: a matrix-level model
// queues the expected pair sequence; a monitor checks every transfer and stall.
module tb_matrix_stream_feeder;

  localparam int LS = 2;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sel, start, out_ack;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data, out_a, out_b;
  logic          out_stb, busy, done, wr_err;

  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];

  int errors = 0;
  int checks = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] hold_a, hold_b;

  matrix_stream_feeder #(.LOG_SIZE(LS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .out_a(out_a), .out_b(out_b),
    .out_stb(out_stb), .out_ack(out_ack), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) b_m[addr[3:2]][addr[1:0]] = data;
    else     a_m[addr[3:2]][addr[1:0]] = data;
  endtask

  // A goes out row by row, B column by column.
  task automatic push_pass();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp_a.push_back(a_m[r][c]);
        exp_b.push_back(b_m[c][r]);
      end
  endtask

  // mode: 0 = ack always, 1 = ack toggling, 2 = random ack
  task automatic run_pass(input int mode, input int wr_at, input int start_at,
                          input int rst_after, input bit wr_b0);
    int stb_cyc = 0, xfers = 0, wr_errs = 0, cyc = 0;
    bit ended = 1'b0, aborted = 1'b0;
    if (wr_b0) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 32'h55;
      b_m[0][0] = 32'h55;
    end
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("first_a", out_a, a_m[0][0]);
    check("first_b", out_b, b_m[0][0]);
    check("start_busy", 32'(busy), 32'd1);
    while (!ended && !aborted && cyc < 200) begin
      if (done) begin
        ended = 1'b1;
      end else begin
        if (wr_err) wr_errs++;
        if (rst_after >= 0 && xfers == rst_after + 1) begin
          out_ack = 1'b0; rst = 1'b1;
          tick();
          rst = 1'b0;
          exp_a.delete(); exp_b.delete();
          check("rst_stb", 32'(out_stb), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          aborted = 1'b1;
        end else begin
          if (out_stb) stb_cyc++;
          case (mode)
            0: out_ack = 1'b1;
            1: out_ack = stb_cyc[0];
            default: out_ack = 1'($urandom_range(0, 1));
          endcase
          if (out_stb && out_ack) xfers++;
          if (stb_cyc == wr_at) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'hDEAD;
          end
          if (stb_cyc == start_at) start = 1'b1;
          tick();
          wr_en = 1'b0; start = 1'b0;
          cyc++;
        end
      end
    end
    out_ack = 1'b0;
    if (aborted) begin
      tick();
      check("no_late_done", 32'(done), 32'd0);
    end else begin
      check("pass_timeout", 32'(ended), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_stb", 32'(out_stb), 32'd0);
      check("pairs_left", 32'(exp_a.size()), 32'd0);
      check("xfer_count", 32'(xfers), 32'd16);
      if (mode == 0) check("stb_cycles", 32'(stb_cyc), 32'd16);
      if (mode == 1) check("stb_cycles", 32'(stb_cyc), 32'd31);
      check("wr_err_pulses", 32'(wr_errs), (wr_at > 0) ? 32'd1 : 32'd0);
      tick();
      check("done_single", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  // Monitor: every transfer consumes one expected pair; stalls must hold outputs.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_stb", 32'(out_stb), 32'd1);
        check("hold_a", out_a, hold_a);
        check("hold_b", out_b, hold_b);
      end
      if (out_stb && out_ack) begin
        if (exp_a.size() == 0) begin
          check("extra_xfer", 32'd1, 32'd0);
        end else begin
          check("pair_a", out_a, exp_a.pop_front());
          check("pair_b", out_b, exp_b.pop_front());
        end
      end
      prev_stall = out_stb && !out_ack;
      hold_a = out_a;
      hold_b = out_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
    start = 1'b0; out_ack = 1'b0;
    tick(); tick();
    check("rst_out_stb", 32'(out_stb), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_done0", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      write_elem(1'b0, 4'(i), 32'(i));
      write_elem(1'b1, 4'(i), 32'(16 + i));
    end
    check("wr_err_idle", 32'(wr_err), 32'd0);

    run_pass(0, -1, -1, -1, 1'b0);
    run_pass(1, -1, -1, -1, 1'b0);
    run_pass(0, 3, -1, -1, 1'b0);
    run_pass(0, -1, -1, -1, 1'b0);
    check("a0_after_drop", a_m[0][0], 32'd0);
    run_pass(0, -1, -1, 5, 1'b0);
    run_pass(0, -1, -1, -1, 1'b0);
    run_pass(0, -1, 8, -1, 1'b0);
    run_pass(0, -1, -1, -1, 1'b1);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        write_elem(1'b0, 4'(i), $urandom);
        write_elem(1'b1, 4'(i), $urandom);
      end
      run_pass(2, -1, -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
